// File: rtl/fwdc_pkg.sv
// rtl/fwdc_pkg.sv - Width derivation helpers shared by the wide-to-narrow FIFO converter
package fwdc_pkg;

  function automatic int fwdc_clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int fwdc_ratio(input int in_w, input int out_w);
    return (out_w > 0) ? (in_w / out_w) : 1;
  endfunction

  // One extra bit so a lane count equal to RATIO is representable.
  function automatic int fwdc_lane_cw(input int in_w, input int out_w);
    return fwdc_clog2(fwdc_ratio(in_w, out_w)) + 1;
  endfunction

  function automatic int fwdc_idx_w(input int in_w, input int out_w);
    int w;
    w = fwdc_clog2(fwdc_ratio(in_w, out_w));
    return (w < 1) ? 1 : w;
  endfunction

  localparam int FWDC_DEF_IN_W  = 256;
  localparam int FWDC_DEF_OUT_W = 64;

  typedef logic [fwdc_idx_w(FWDC_DEF_IN_W, FWDC_DEF_OUT_W)-1:0] lane_idx_t;

endpackage

// File: rtl/fifo_width_down_conv_if.sv
// rtl/fifo_width_down_conv_if.sv - Word-in / lane-out handshake bundle for fifo_width_down_conv
interface fifo_width_down_conv_if
  import fwdc_pkg::*;
#(
  parameter int IN_W  = 256,
  parameter int OUT_W = 64
) ();

  localparam int LANE_CW = fwdc_lane_cw(IN_W, OUT_W);

  logic               s_valid;
  logic               s_ready;
  logic [IN_W-1:0]    s_data;
  logic [LANE_CW-1:0] s_lanes;

  logic               m_valid;
  logic               m_ready;
  logic [OUT_W-1:0]   m_data;
  logic               m_last;

  // master drives words in and lane acceptance; slave is the converter itself.
  modport master (
    output s_valid, s_data, s_lanes, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_lanes, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - Synchronous word FIFO with head-of-queue read, occupancy and full/empty
module sync_fifo_ram #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W:0]   o_fill_level,
  output logic [ADDR_W:0]   o_fill_next,
  output logic              o_full,
  output logic              o_empty
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_wr;
  logic              w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  // Gated here as well so a careless caller can never corrupt the pointers.
  assign w_wr = i_wr_en & ~o_full;
  assign w_rd = i_rd_en & ~o_empty;

  assign o_rd_data    = r_mem[r_rd_ptr];
  assign o_fill_level = r_count;
  assign o_fill_next  = r_count + CW'(w_wr) - CW'(w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_count <= o_fill_next;
    end
  end

endmodule

// File: rtl/fifo_width_down_conv.sv
// rtl/fifo_width_down_conv.sv - Buffered IN_W-to-OUT_W stream converter, LSB lane first, with watermarks
// Optional FWDC_PARTIAL_EN: store s_lanes per word and stop each word at its last valid lane.
module fifo_width_down_conv
  import fwdc_pkg::*;
#(
  parameter int IN_W     = 256,
  parameter int OUT_W    = 64,
  parameter int ADDR_W   = 4,
  parameter int LOW_THR  = 1,
  parameter int HIGH_THR = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_width_down_conv_if.slave bus,
  output logic [ADDR_W:0]       o_fill_level,
  output logic                  o_need_data,
  output logic                  o_no_need_data,
  output logic                  o_overflow
);

  localparam int RATIO   = fwdc_ratio(IN_W, OUT_W);
  localparam int LANE_CW = fwdc_lane_cw(IN_W, OUT_W);
  localparam int IDX_W   = fwdc_idx_w(IN_W, OUT_W);
  localparam int DEPTH   = 2 ** ADDR_W;
`ifdef FWDC_PARTIAL_EN
  localparam int ENTRY_W = IN_W + LANE_CW;
`else
  localparam int ENTRY_W = IN_W;
`endif

  if ((OUT_W <= 0) || (IN_W % OUT_W != 0)) begin : g_bad_ratio
    $error("fifo_width_down_conv: IN_W (%0d) must be a multiple of OUT_W (%0d)", IN_W, OUT_W);
  end
  if (!((LOW_THR < HIGH_THR) && (HIGH_THR <= DEPTH))) begin : g_bad_thr
    $error("fifo_width_down_conv: need LOW_THR (%0d) < HIGH_THR (%0d) <= %0d", LOW_THR, HIGH_THR, DEPTH);
  end

  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_rd_entry;
  logic [IN_W-1:0]    w_rd_word;
  logic [ADDR_W:0]    w_fill_next;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_load;
  logic               w_fire;
  logic               w_last;
  logic [IDX_W-1:0]   w_load_last;

  logic [IN_W-1:0]    r_hold_word;
  logic               r_hold_vld;
  logic [IDX_W-1:0]   r_lane_idx;
  logic [IDX_W-1:0]   r_last_idx;
  logic               r_need_data;
  logic               r_no_need_data;
  logic               r_overflow;

`ifdef FWDC_PARTIAL_EN
  logic [LANE_CW-1:0] w_rd_lanes;

  assign w_wr_entry = {bus.s_lanes, bus.s_data};
  assign w_rd_lanes = w_rd_entry[IN_W +: LANE_CW];

  // Zero (or an out-of-range count) means a full word.
  always_comb begin
    w_load_last = IDX_W'(RATIO - 1);
    if ((w_rd_lanes != '0) && (int'(w_rd_lanes) <= RATIO)) begin
      w_load_last = IDX_W'(int'(w_rd_lanes) - 1);
    end
  end
`else
  logic w_unused_lanes;

  assign w_unused_lanes = ^bus.s_lanes;
  assign w_wr_entry     = bus.s_data;
  assign w_load_last    = IDX_W'(RATIO - 1);
`endif

  assign w_rd_word = w_rd_entry[IN_W-1:0];
  assign w_push    = bus.s_valid & ~w_full;

  sync_fifo_ram #(
    .DATA_W (ENTRY_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_wr_en      (w_push),
    .i_wr_data    (w_wr_entry),
    .i_rd_en      (w_load),
    .o_rd_data    (w_rd_entry),
    .o_fill_level (o_fill_level),
    .o_fill_next  (w_fill_next),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  assign w_fire = r_hold_vld & bus.m_ready;
  assign w_last = r_hold_vld & (r_lane_idx == r_last_idx);
  // Reload on the same edge the last lane leaves so words follow each other without a gap.
  assign w_load = ~w_empty & (~r_hold_vld | (w_fire & w_last));

  assign bus.s_ready = ~w_full;
  assign bus.m_valid = r_hold_vld;
  assign bus.m_data  = r_hold_word[int'(r_lane_idx) * OUT_W +: OUT_W];
  assign bus.m_last  = w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_word <= '0;
      r_hold_vld  <= 1'b0;
      r_lane_idx  <= '0;
      r_last_idx  <= '0;
    end else if (w_load) begin
      r_hold_word <= w_rd_word;
      r_hold_vld  <= 1'b1;
      r_lane_idx  <= '0;
      r_last_idx  <= w_load_last;
    end else if (w_fire) begin
      if (w_last) begin
        r_hold_vld <= 1'b0;
        r_lane_idx <= '0;
      end else begin
        r_lane_idx <= r_lane_idx + IDX_W'(1);
      end
    end
  end

  // Flags track the occupancy that fill_level will show after this edge, keeping the two aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_need_data    <= 1'b1;
      r_no_need_data <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_need_data    <= (int'(w_fill_next) <= LOW_THR);
      r_no_need_data <= (int'(w_fill_next) >= HIGH_THR);
      r_overflow     <= r_overflow | (bus.s_valid & w_full);
    end
  end

  assign o_need_data    = r_need_data;
  assign o_no_need_data = r_no_need_data;
  assign o_overflow     = r_overflow;

endmodule
